// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//   Captures one OV7670 RGB565 frame (byte stream) and writes it as RGB332
//   pixels into the H_PIX x V_PIX frame buffer read by the colour analyser.
//   Ports:
//     clk, rst        system clock, synchronous active-high reset
//     init            start request, honoured only in IDLE / DONE
//     cam_pclk/href/vsync/data   asynchronous camera pins (pclk used as data)
//     mem_addr/data/we  frame buffer write port, one strobe per pixel
//     busy            high while waiting for vsync or capturing
//     done            level, frame finished; short_frame valid with it
module cam_frame_writer #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          cam_pclk,
    input  logic          cam_href,
    input  logic          cam_vsync,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          short_frame
);

    localparam int TOTAL = H_PIX * V_PIX;
    localparam int CW    = $clog2(H_PIX + 1);
    localparam int RW    = $clog2(V_PIX + 1);
    localparam logic [CW-1:0] COL_END  = CW'(H_PIX);
    localparam logic [RW-1:0] ROW_END  = RW'(V_PIX);
    localparam logic [AW:0]   WCNT_END = (AW+1)'(TOTAL);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    // ---------------- input synchronisers ----------------
    logic [1:0] pclk_sy, href_sy, vs_sy;
    logic [7:0] data_s1, data_s2;
    logic       pclk_q, href_q, vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sy <= '0;
            href_sy <= '0;
            vs_sy   <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
            pclk_q  <= 1'b0;
            href_q  <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            pclk_sy <= {pclk_sy[0], cam_pclk};
            href_sy <= {href_sy[0], cam_href};
            vs_sy   <= {vs_sy[0], cam_vsync};
            data_s1 <= cam_data;
            data_s2 <= data_s1;
            pclk_q  <= pclk_sy[1];
            href_q  <= href_sy[1];
            vs_q    <= vs_sy[1];
        end
    end

    // Data and href come from the same stage as the pclk sample that fires pe.
    logic href, pe, href_fall, vs_rise, vs_fall;
    assign href      = href_sy[1];
    assign pe        = pclk_sy[1] & ~pclk_q;
    assign href_fall = href_q & ~href_sy[1];
    assign vs_rise   = vs_sy[1] & ~vs_q;
    assign vs_fall   = vs_q & ~vs_sy[1];

    // ---------------- capture FSM ----------------
    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW:0]   wcnt;
    logic          phase;
    logic          seen;      // at least one pixel completed on this line
    logic [5:0]    byte1_rg;  // byte1[7:5], byte1[2:0]

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            wcnt        <= '0;
            phase       <= 1'b0;
            seen        <= 1'b0;
            byte1_rg    <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    phase <= 1'b0;
                    if (init) begin
                        state       <= WAIT_VS;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        short_frame <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    // Counters are cleared here so a partial frame in flight
                    // when we armed never leaks into the buffer.
                    phase <= 1'b0;
                    col   <= '0;
                    row   <= '0;
                    wcnt  <= '0;
                    seen  <= 1'b0;
                    if (vs_fall) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (wcnt == WCNT_END) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        phase <= 1'b0;
                    end else if (vs_rise) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        short_frame <= 1'b1;
                        phase       <= 1'b0;
                    end else if (href_fall) begin
                        // A trailing odd byte is dropped by clearing phase.
                        col   <= '0;
                        phase <= 1'b0;
                        seen  <= 1'b0;
                        if (seen && row < ROW_END) row <= row + RW'(1);
                    end else if (pe && href) begin
                        if (!phase) begin
                            byte1_rg <= {data_s2[7:5], data_s2[2:0]};
                            phase    <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            seen  <= 1'b1;
                            if (col < COL_END) col <= col + CW'(1);
                            if (col < COL_END && row < ROW_END) begin
                                mem_we   <= 1'b1;
                                mem_addr <= wcnt[AW-1:0];
                                mem_data <= {byte1_rg, data_s2[4:3]};
                                wcnt     <= wcnt + (AW+1)'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
